// File: rtl/rle_pkg.sv
// Shared definitions for the RLE decoder: FSM states, pair field layout
// inside a compressed word, and output packing width.
package rle_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int FILL_W         = 3;

  // Each compressed word carries two {byte, count} pairs, low pair first.
  localparam int PAIR0_CNT_LSB  = 0;
  localparam int PAIR0_BYTE_LSB = 8;
  localparam int PAIR1_CNT_LSB  = 16;
  localparam int PAIR1_BYTE_LSB = 24;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    EXPAND,
    WRITE,
    FLUSH
  } state_t;

  function automatic logic [7:0] pair_byte(input logic [31:0] w, input logic sel);
    return sel ? w[PAIR1_BYTE_LSB +: 8] : w[PAIR0_BYTE_LSB +: 8];
  endfunction

  function automatic logic [7:0] pair_count(input logic [31:0] w, input logic sel);
    return sel ? w[PAIR1_CNT_LSB +: 8] : w[PAIR0_CNT_LSB +: 8];
  endfunction

endpackage

// File: rtl/rle_byte_packer.sv
// Accumulates bytes little-endian into a 32-bit word; unused upper bytes
// stay zero so a partial word can be written out as-is.
module rle_byte_packer
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        byte_val,
  output logic [31:0]       word,
  output logic [FILL_W-1:0] fill,
  output logic              full
);

  assign full = (fill == FILL_W'(BYTES_PER_WORD));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word <= '0;
      fill <= '0;
    end else if (clear) begin
      word <= '0;
      fill <= '0;
    end else if (push && !full) begin
      word[{fill[1:0], 3'b000} +: 8] <= byte_val;
      fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/rle_decode.sv
// Run-length decoder: reads {byte,count} pair words from a dual-port SRAM
// port and writes the expanded byte stream back as packed 32-bit words.
module rle_decode
  import rle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] rle_addr,
  input  logic [31:0] rle_size,
  input  logic [31:0] message_addr,
  output logic [31:0] message_size,
  output logic        done,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic        port_A_we,
  output logic [31:0] port_A_data_in,
  input  logic [31:0] port_A_data_out
);

  state_t            state, state_nxt;
  logic [15:0]       rd_ptr, wr_ptr;
  logic [29:0]       words_left;
  logic [31:0]       cur_word;
  logic              pair_sel;
  logic [7:0]        cnt_left;

  logic              pack_clear, pack_push, pack_full;
  logic [31:0]       pack_word;
  logic [FILL_W-1:0] pack_fill;
  logic [7:0]        pack_byte;

  logic              empty_frame;
  logic              unused_bits;

  assign port_A_clk  = clk;
  assign empty_frame = (rle_size[31:2] == 30'd0);
  assign pack_byte   = pair_byte(cur_word, pair_sel);
  assign unused_bits = ^{rle_addr[31:16], rle_size[1:0], message_addr[31:16], pack_full};

  rle_byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pack_clear),
    .push     (pack_push),
    .byte_val (pack_byte),
    .word     (pack_word),
    .fill     (pack_fill),
    .full     (pack_full)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    port_A_addr    = '0;
    port_A_we      = 1'b0;
    port_A_data_in = '0;
    pack_clear     = 1'b0;
    pack_push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          pack_clear = 1'b1;
          state_nxt  = empty_frame ? IDLE : RD_REQ;
        end
      end
      RD_REQ: begin
        port_A_addr = rd_ptr;
        state_nxt   = RD_WAIT;
      end
      RD_WAIT: state_nxt = EXPAND;
      EXPAND: begin
        if (cnt_left != 8'd0) begin
          pack_push = 1'b1;
          // The byte pushed now completes the word, so write it next cycle.
          if (pack_fill == FILL_W'(BYTES_PER_WORD - 1)) state_nxt = WRITE;
        end else if (pair_sel) begin
          state_nxt = (words_left != 30'd0) ? RD_REQ : FLUSH;
        end
      end
      WRITE: begin
        port_A_we      = 1'b1;
        port_A_addr    = wr_ptr;
        port_A_data_in = pack_word;
        pack_clear     = 1'b1;
        state_nxt      = EXPAND;
      end
      FLUSH: begin
        if (pack_fill != '0) begin
          port_A_we      = 1'b1;
          port_A_addr    = wr_ptr;
          port_A_data_in = pack_word;
        end
        pack_clear = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      words_left   <= '0;
      cur_word     <= '0;
      pair_sel     <= 1'b0;
      cnt_left     <= '0;
      message_size <= '0;
      done         <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            rd_ptr       <= rle_addr[15:0];
            wr_ptr       <= message_addr[15:0];
            words_left   <= rle_size[31:2];
            message_size <= '0;
            pair_sel     <= 1'b0;
            cnt_left     <= '0;
            done         <= empty_frame;
          end
        end
        RD_WAIT: begin
          cur_word   <= port_A_data_out;
          pair_sel   <= 1'b0;
          cnt_left   <= pair_count(port_A_data_out, 1'b0);
          rd_ptr     <= rd_ptr + 16'd4;
          words_left <= words_left - 30'd1;
        end
        EXPAND: begin
          if (cnt_left != 8'd0) begin
            cnt_left     <= cnt_left - 8'd1;
            message_size <= message_size + 32'd1;
          end else if (!pair_sel) begin
            // Low pair exhausted (or zero-count padding): move to the high pair.
            pair_sel <= 1'b1;
            cnt_left <= pair_count(cur_word, 1'b1);
          end
        end
        WRITE: wr_ptr <= wr_ptr + 16'd4;
        FLUSH: begin
          if (pack_fill != '0) wr_ptr <= wr_ptr + 16'd4;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_decode.sv
// Self-checking bench for rle_decode: table-driven frames against a
// byte-level reference model, plus reset-abort and round-trip sequences.
module tb_rle_decode;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] rle_addr, rle_size, message_addr, message_size;
  logic        done, port_A_clk, port_A_we;
  logic [15:0] port_A_addr;
  logic [31:0] port_A_data_in, port_A_data_out;

  always #5 clk = ~clk;

  rle_decode dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .rle_addr        (rle_addr),
    .rle_size        (rle_size),
    .message_addr    (message_addr),
    .message_size    (message_size),
    .done            (done),
    .port_A_clk      (port_A_clk),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out)
  );

  // Synchronous SRAM model with a bench-side load port.
  logic [31:0] mem [0:16383];
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [31:0] load_data = '0;

  always @(posedge clk) begin
    if (load_en)        mem[load_addr[15:2]]   <= load_data;
    else if (port_A_we) mem[port_A_addr[15:2]] <= port_A_data_in;
    port_A_data_out <= mem[port_A_addr[15:2]];
  end

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] w0;
    logic [31:0] w1;
    int          n;
    logic [31:0] exp_size;
    int          exp_writes;
    bit          stray;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [31:0] src_words [0:15];
  int          src_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Reference: expand pairs to a byte stream, then cut it into LE words.
  task automatic model(input logic [15:0] maddr);
    logic [7:0]  bq[$];
    logic [31:0] w, d;
    exp_q.delete();
    for (int i = 0; i < src_n; i++) begin
      w = src_words[i];
      repeat (int'(w[7:0]))   bq.push_back(w[15:8]);
      repeat (int'(w[23:16])) bq.push_back(w[31:24]);
    end
    for (int k = 0; k < bq.size(); k += 4) begin
      d = '0;
      for (int j = 0; j < 4; j++)
        if (k + j < bq.size()) d[8*j +: 8] = bq[k + j];
      exp_q.push_back('{addr: maddr + 16'(k), data: d});
    end
  endtask

  task automatic run_decode(input string tag, input logic [15:0] raddr, input logic [15:0] maddr,
                            input logic [31:0] exp_size, input int exp_writes, input bit stray);
    wr_t e;
    int  nwr = 0;
    int  cyc = 0;
    for (int i = 0; i < src_n; i++) load_word(raddr + 16'(4 * i), src_words[i]);
    // A word past the frame that would change the output if it were read.
    load_word(raddr + 16'(4 * src_n), 32'h55FF55FF);
    model(maddr);
    rle_addr     = {16'hA5A5, raddr};
    rle_size     = 32'(src_n * 4) | 32'h3;
    message_addr = {16'h5A5A, maddr};
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    while (cyc < 5000 && !done) begin
      if (stray && cyc == 5) begin
        start    = 1'b1;
        rle_addr = 32'h0000_DEAD;
        rle_size = 32'h0;
      end else if (stray && cyc == 6) begin
        start    = 1'b0;
      end
      if (port_A_we) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s extra write", tag), {16'h0, port_A_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s wr%0d addr", tag, nwr), {16'h0, port_A_addr}, {16'h0, e.addr});
          check($sformatf("%s wr%0d data", tag, nwr), port_A_data_in, e.data);
        end
        nwr++;
      end
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s done", tag), {31'h0, done}, 32'h1);
    check($sformatf("%s message_size", tag), message_size, exp_size);
    check($sformatf("%s write count", tag), 32'(nwr), 32'(exp_writes));
    check($sformatf("%s missing writes", tag), 32'(exp_q.size()), 32'h0);
    if (src_n == 0) check($sformatf("%s done latency", tag), 32'(cyc <= 2), 32'h1);
  endtask

  vec_t        vecs[$];
  logic [7:0]  orig[$];
  logic [15:0] pairs[$];
  int          mism, we_seen, run_len;
  logic [31:0] mw;

  initial begin
    vecs.push_back('{"two_pairs", 32'h41034202, 32'h0, 1, 32'd5,   2,   1'b0});
    vecs.push_back('{"one_full",  32'h00005A04, 32'h0, 1, 32'd4,   1,   1'b0});
    vecs.push_back('{"max_count", 32'h00FF00FF, 32'h0, 1, 32'd510, 128, 1'b0});
    vecs.push_back('{"all_pad",   32'h00000000, 32'h0, 1, 32'd0,   0,   1'b0});
    vecs.push_back('{"pad_low",   32'h7701AA00, 32'h0, 1, 32'd1,   1,   1'b0});
    vecs.push_back('{"two_words", 32'h11022203, 32'h33010000, 2, 32'd6, 2, 1'b1});
    vecs.push_back('{"empty",     32'h0,        32'h0, 0, 32'd0,   0,   1'b0});

    reset = 1'b1; start = 1'b0;
    rle_addr = '0; rle_size = '0; message_addr = '0;
    repeat (3) @(negedge clk);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset message_size", message_size, 32'h0);
    check("reset we", {31'h0, port_A_we}, 32'h0);
    check("reset addr", {16'h0, port_A_addr}, 32'h0);
    check("reset data_in", port_A_data_in, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      src_words[0] = vecs[i].w0;
      src_words[1] = vecs[i].w1;
      src_n        = vecs[i].n;
      run_decode(vecs[i].name, 16'h0100 + 16'(i * 16), 16'h2000 + 16'(i * 1024),
                 vecs[i].exp_size, vecs[i].exp_writes, vecs[i].stray);
    end

    // Reset in the middle of a long expansion abandons the decode.
    src_words[0] = 32'h00FF00FF;
    src_n        = 1;
    load_word(16'h0300, src_words[0]);
    rle_addr = 32'h0300; rle_size = 32'h4; message_addr = 32'h6000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort we", {31'h0, port_A_we}, 32'h0);
    check("abort done", {31'h0, done}, 32'h0);
    check("abort message_size", message_size, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    we_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (port_A_we) we_seen++;
    end
    check("abort no access", 32'(we_seen), 32'h0);
    src_words[0] = 32'h41034202;
    src_n        = 1;
    run_decode("after_reset", 16'h0340, 16'h6100, 32'd5, 2, 1'b0);

    // Round trip through a bench-side encoder, frame wrapping past 0xFFFF.
    for (int i = 0; i < 7; i++)   orig.push_back(8'h10);
    orig.push_back(8'h20);
    for (int i = 0; i < 300; i++) orig.push_back(8'h30);
    for (int i = 0; i < 3; i++)   orig.push_back(8'h41);
    orig.push_back(8'h42);
    for (int i = 0; i < orig.size(); i += run_len) begin
      run_len = 1;
      while (i + run_len < orig.size() && orig[i + run_len] == orig[i] && run_len < 255) run_len++;
      pairs.push_back({orig[i], 8'(run_len)});
    end
    src_n = 0;
    for (int p = 0; p < pairs.size(); p += 2) begin
      src_words[src_n] = {(p + 1 < pairs.size()) ? pairs[p + 1] : 16'h0000, pairs[p]};
      src_n++;
    end
    run_decode("roundtrip", 16'hFFF8, 16'h4000, 32'd312, 78, 1'b0);
    mism = 0;
    for (int i = 0; i < orig.size(); i++) begin
      mw = mem[14'((16'h4000 + 16'(i)) >> 2)];
      if (mw[8 * (i % 4) +: 8] !== orig[i]) mism++;
    end
    check("roundtrip byte mismatches", 32'(mism), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rle_decode.md
RLE_DECODE -- requirements
Module: rle_decode

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
REQ-002 SHALL have the following other ports:
- start  in  1  pulse; begin decoding (sampled in IDLE only)
- rle_addr  in  32  byte address of compressed frame; low 16 bits used
- rle_size  in  32  compressed length in bytes; multiple of 4, low 2 bits ignored
- message_addr  in  32  byte address for decoded output; low 16 bits used
- message_size  out  32  decoded bytes written so far; final value valid with done
- done  out  1  level; high in IDLE after a completed decode until next start
- port_A_clk  out  1  dpsram clock, driven by clk
- port_A_addr  out  16  dpsram byte address
- port_A_we  out  1  1 = write, 0 = read
- port_A_data_in  out  32  dpsram write data
- port_A_data_out  in  32  dpsram read data, valid cycle after read address presented

Function
REQ-003 SHALL treat each compressed word as two pairs, processed low then high: pair0 = [15:8] byte, [7:0] count; pair1 = [31:24] byte, [23:16] count.
REQ-004 SHALL emit each pair's byte count times (count 0..255); count 0 SHALL be skipped (padding) with no output.
REQ-005 SHALL pack output bytes little-endian: first byte of a word in [7:0], fourth in [31:24].
REQ-006 SHALL use states IDLE, RD_REQ, RD_WAIT, EXPAND, WRITE, FLUSH.
REQ-007 IDLE: on start, latch addresses, clear message_size, byte counters and done, go RD_REQ; if rle_size[31:2]==0 go directly to IDLE with done=1 the next cycle.
REQ-008 RD_REQ: drive port_A_addr=read pointer, we=0; next RD_WAIT. RD_WAIT: capture port_A_data_out, read pointer += 4, next EXPAND.
REQ-009 EXPAND: one output byte per cycle into the packer, message_size += 1; when the packer holds 4 bytes go WRITE; when both pairs are exhausted go RD_REQ if compressed words remain, else FLUSH.
REQ-010 WRITE: one cycle, we=1, addr=write pointer, data=packed word; write pointer += 4, packer cleared; return to EXPAND (or RD_REQ/FLUSH if the pair is exhausted).
REQ-011 FLUSH: if the packer holds 1-3 bytes, write one word with unused upper bytes zero; then IDLE with done=1.
REQ-012 port_A_we SHALL be high only in WRITE/FLUSH write cycles; read and write never in the same cycle.
REQ-013 pointers SHALL be 16-bit and wrap modulo 65536; message_size SHALL be 32-bit and not saturate.
REQ-014 start outside IDLE SHALL be ignored; start in IDLE with done=1 SHALL restart.
REQ-015 decode of N compressed words SHALL issue exactly N reads and ceil(message_size/4) writes.

Reset
REQ-016 On reset: state IDLE; done=0, message_size=0, port_A_we=0, port_A_addr=0, port_A_data_in=0, packer and counters cleared; a decode in progress is abandoned with no further memory access.

Structure
REQ-017 A shared package rle_pkg SHALL hold the state enum, the pair field offsets, and the bytes-per-word constant (4).
REQ-018 A sub-module rle_byte_packer SHALL accumulate bytes into a 32-bit word with fill count, full flag and clear.

Verification
REQ-019 Word 0x41034202, rle_size=4 -> writes 0x41414242 then 0x00000041; message_size=5; done=1.
REQ-020 Word 0x00005A04, rle_size=4 -> exactly one write, 0x5A5A5A5A; message_size=4.
REQ-021 rle_size=0 -> no writes, message_size=0, done high within 2 cycles of start.
REQ-022 Word 0x00FF00FF -> 510 bytes 0x00, 128 writes (last 0x00000000 partial), message_size=510.
REQ-023 Reset asserted mid-EXPAND -> we=0 and done=0 immediately; new start decodes correctly from scratch.
REQ-024 Encode-then-decode round trip with rle_addr=0xFFF8 (pointer wrap) -> output matches original message byte-for-byte.
